// File: rtl/vive_spi_frame_reader_if.sv
// -----------------------------------------------------------------------------
// vive_spi_frame_reader_if
//   SPI link between the host-side frame reader and the capture board's
//   slave port.
//   ss   : active-low chip select         (master -> slave)
//   sclk : SCK, mode 0, idle low          (master -> slave)
//   mosi : master data out, unused (0)    (master -> slave)
//   miso : slave data out, asynchronous   (slave  -> master)
// -----------------------------------------------------------------------------
interface vive_spi_frame_reader_if;
  logic ss;
  logic sclk;
  logic mosi;
  logic miso;

  modport master (output ss, output sclk, output mosi, input miso);
  modport slave  (input ss, input sclk, input mosi, output miso);
endinterface

// File: rtl/vive_spi_frame_reader.sv
// -----------------------------------------------------------------------------
// vive_spi_frame_reader
//   SPI master that drains one 8-byte capture frame (four 16-bit sensor
//   timestamps F, C, L, R, little-endian per word) from the capture board
//   every time data_ready rises, and presents the words with a one-cycle
//   frame_valid strobe. A fall of data_ready mid-frame aborts the transfer
//   (frame_err strobe) because the slave rewinds its byte address then.
//
// Ports
//   clk, rst     : system clock, asynchronous active-high reset
//   enable       : gates the start of new frames only
//   data_ready   : frame-available line from the capture board (async)
//   s_spi        : SPI master port (ss, sclk, mosi out; miso in, async)
//   F, C, L, R   : last complete frame, updated only with frame_valid
//   frame_valid  : 1-cycle pulse, F/C/L/R carry a new frame this cycle
//   frame_err    : 1-cycle pulse, frame aborted
//   busy         : high while chip select is asserted
// -----------------------------------------------------------------------------
module vive_spi_frame_reader #(
  parameter int unsigned CLK_DIV   = 4,  // clk cycles per SCK phase, 4..255
  parameter int unsigned SETUP_CYC = 4,  // SS low to first SCK low phase
  parameter int unsigned GAP_CYC   = 8,  // SCK idle low between bytes
  parameter int unsigned HOLD_CYC  = 4   // last SCK fall to SS high
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          data_ready,
  vive_spi_frame_reader_if.master       s_spi,
  output logic [15:0]                   F,
  output logic [15:0]                   C,
  output logic [15:0]                   L,
  output logic [15:0]                   R,
  output logic                          frame_valid,
  output logic                          frame_err,
  output logic                          busy
);

  typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, GAP, HOLD, FINISH} state_t;

  state_t      state, next_state;
  logic        dr_meta, sync_dr, sync_dr_d, miso_meta, sync_miso;
  logic        dr_rise, phase_done, abort, active;
  logic [7:0]  cnt, phase_last;
  logic [2:0]  bit_cnt, byte_cnt;
  logic [6:0]  byte_sr;
  logic [63:0] shadow;   // byte k at [8k +: 8]: {R, L, C, F}
  logic        ss_q, sclk_q;

  // Two-flop synchronizers for the asynchronous board lines.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbours, exactly like the hardware.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dr_meta   <= 1'b0;
      sync_dr   <= 1'b0;
      sync_dr_d <= 1'b0;
      miso_meta <= 1'b0;
      sync_miso <= 1'b0;
    end else begin
      dr_meta   <= data_ready;
      sync_dr   <= dr_meta;
      sync_dr_d <= sync_dr;
      miso_meta <= s_spi.miso;
      sync_miso <= miso_meta;
    end
  end

  assign dr_rise = sync_dr & ~sync_dr_d;
  assign active  = (state == SETUP) || (state == LOW) || (state == HIGH) ||
                   (state == GAP)   || (state == HOLD);

  // Length of the current timed phase, minus one.
  always_comb begin
    // NOTE: every always_comb output gets a default first; a path that leaves
    // a variable unassigned would infer a latch.
    phase_last = 8'd0;
    case (state)
      SETUP:     phase_last = 8'(SETUP_CYC - 1);
      LOW, HIGH: phase_last = 8'(CLK_DIV - 1);
      GAP:       phase_last = 8'(GAP_CYC - 1);
      HOLD:      phase_last = 8'(HOLD_CYC - 1);
      default:   phase_last = 8'd0;
    endcase
  end

  assign phase_done = (cnt == phase_last);

  // Next-state logic.
  always_comb begin
    next_state = state;
    abort      = 1'b0;
    case (state)
      IDLE:   if (dr_rise && enable) next_state = SETUP;
      SETUP:  if (phase_done) next_state = LOW;
      LOW:    if (phase_done) next_state = HIGH;
      HIGH:
        if (phase_done) begin
          if (bit_cnt != 3'd7)       next_state = LOW;
          else if (byte_cnt != 3'd7) next_state = GAP;
          else                       next_state = HOLD;
        end
      GAP:    if (phase_done) next_state = LOW;
      HOLD:   if (phase_done) next_state = FINISH;
      FINISH: next_state = IDLE;
      default: next_state = IDLE;
    endcase
    // The slave rewinds its byte address when data_ready falls, so any
    // partially read frame is worthless.
    if (active && !sync_dr) begin
      next_state = IDLE;
      abort      = 1'b1;
    end
  end

  // State register, phase/bit/byte counters and registered outputs. SS, SCK
  // and the strobes are decoded from next_state so they line up with the
  // state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= 8'd0;
      bit_cnt     <= 3'd0;
      byte_cnt    <= 3'd0;
      ss_q        <= 1'b1;
      sclk_q      <= 1'b0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      F           <= 16'd0;
      C           <= 16'd0;
      L           <= 16'd0;
      R           <= 16'd0;
    end else begin
      state <= next_state;

      if (state == IDLE || next_state != state) cnt <= 8'd0;
      else                                      cnt <= cnt + 8'd1;

      if (state == IDLE) begin
        bit_cnt  <= 3'd0;
        byte_cnt <= 3'd0;
      end else if (state == HIGH && phase_done) begin
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) byte_cnt <= byte_cnt + 3'd1;
      end

      ss_q        <= !((next_state == SETUP) || (next_state == LOW) ||
                       (next_state == HIGH)  || (next_state == GAP) ||
                       (next_state == HOLD));
      sclk_q      <= (next_state == HIGH);
      frame_valid <= (next_state == FINISH);
      frame_err   <= abort;

      if (next_state == FINISH) begin
        F <= shadow[15:0];
        C <= shadow[31:16];
        L <= shadow[47:32];
        R <= shadow[63:48];
      end
    end
  end

  // Byte assembly, MSB first, sampled at the end of each SCK high phase.
  // NOTE: these datapath registers have no reset; every bit is rewritten
  // before FINISH publishes it, and an aborted frame is simply never loaded.
  always_ff @(posedge clk) begin
    if (state == HIGH && phase_done) begin
      byte_sr <= {byte_sr[5:0], sync_miso};
      if (bit_cnt == 3'd7) shadow[{byte_cnt, 3'b000} +: 8] <= {byte_sr, sync_miso};
    end
  end

  assign s_spi.ss   = ss_q;
  assign s_spi.sclk = sclk_q;
  assign s_spi.mosi = 1'b0;
  assign busy       = ~ss_q;

endmodule

// File: tb/tb_vive_spi_frame_reader.sv
// -----------------------------------------------------------------------------
// tb_vive_spi_frame_reader
//   Bench for vive_spi_frame_reader: behavioural capture-board slave, a
//   negedge bus monitor, and a frame scoreboard (expected words pushed when a
//   frame is launched, popped when frame_valid is seen).
// -----------------------------------------------------------------------------
module tb_vive_spi_frame_reader;

  localparam int CLK_DIV   = 4;
  localparam int SETUP_CYC = 4;
  localparam int GAP_CYC   = 8;
  localparam int HOLD_CYC  = 4;

  typedef struct packed {
    logic [15:0] f, c, l, r;
  } frame_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        data_ready;
  logic [15:0] F, C, L, R;
  logic        frame_valid, frame_err, busy;

  vive_spi_frame_reader_if spi ();

  vive_spi_frame_reader #(
    .CLK_DIV(CLK_DIV), .SETUP_CYC(SETUP_CYC), .GAP_CYC(GAP_CYC), .HOLD_CYC(HOLD_CYC)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .data_ready(data_ready),
    .s_spi(spi), .F(F), .C(C), .L(L), .R(R),
    .frame_valid(frame_valid), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int     checks = 0;
  int     errors = 0;
  frame_t exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------- slave --
  // Mode 0 slave: MSB of byte 0 appears when SS falls, next bit after every
  // SCK falling edge. slave_mem holds {R, L, C, F}, byte k at [8k +: 8].
  logic [63:0] slave_mem = 64'd0;
  int          bit_idx = 0;
  logic        s_prev_ss = 1'b1, s_prev_sck = 1'b0;

  function automatic logic slave_bit(input logic [63:0] mem, input int idx);
    if (idx > 63) return 1'b0;
    return mem[(idx / 8) * 8 + 7 - (idx % 8)];
  endfunction

  initial spi.miso = 1'b0;

  always @(negedge clk) begin
    if (s_prev_ss && !spi.ss) begin
      bit_idx  = 0;
      spi.miso = slave_bit(slave_mem, 0);
    end else if (!spi.ss && s_prev_sck && !spi.sclk) begin
      bit_idx++;
      spi.miso = slave_bit(slave_mem, bit_idx);
    end
    s_prev_ss  = spi.ss;
    s_prev_sck = spi.sclk;
  end

  // -------------------------------------------------------------- monitor --
  int   ss_falls = 0, ss_low_cnt = 0, sck_rises = 0, first_rise = 0;
  int   low_run = 0, long_lows = 0, odd_lows = 0, hold_run = 0;
  int   mosi_bad = 0, fv_count = 0, fe_count = 0, both_high = 0;
  logic m_prev_ss = 1'b1, m_prev_sck = 1'b0;

  always @(negedge clk) begin
    if (m_prev_ss && !spi.ss) begin
      ss_falls++;
      ss_low_cnt = 0; sck_rises = 0; first_rise = 0;
      low_run = 0; long_lows = 0; odd_lows = 0;
    end
    if (!m_prev_ss && spi.ss) hold_run = low_run;
    if (!spi.ss) begin
      ss_low_cnt++;
      if (spi.sclk && !m_prev_sck) begin
        sck_rises++;
        if (sck_rises == 1)                     first_rise = ss_low_cnt - 1;
        else if (low_run == GAP_CYC + CLK_DIV)  long_lows++;
        else if (low_run != CLK_DIV)            odd_lows++;
        low_run = 0;
      end else if (!spi.sclk) begin
        low_run++;
      end
    end
    if (spi.mosi !== 1'b0)          mosi_bad++;
    if (frame_valid)                fv_count++;
    if (frame_err)                  fe_count++;
    if (frame_valid && frame_err)   both_high++;
    m_prev_ss  = spi.ss;
    m_prev_sck = spi.sclk;
  end

  // ----------------------------------------------------------- scoreboard --
  always @(negedge clk) begin
    if (frame_valid) begin
      check("frame_expected", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        frame_t e;
        e = exp_q.pop_front();
        check("sb_F", 64'(F), 64'(e.f));
        check("sb_C", 64'(C), 64'(e.c));
        check("sb_L", 64'(L), 64'(e.l));
        check("sb_R", 64'(R), 64'(e.r));
      end
    end
  end

  // -------------------------------------------------------------- helpers --
  task automatic cycle(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic launch(input frame_t fr, input bit expect_valid);
    slave_mem = {fr.r, fr.l, fr.c, fr.f};
    if (expect_valid) exp_q.push_back(fr);
    data_ready = 1'b1;
  endtask

  task automatic wait_fv();
    bit seen = 1'b0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      cycle(1);
      if (frame_valid) seen = 1'b1;
    end
    check("frame_valid_seen", 64'(seen), 64'd1);
    cycle(1);  // let the monitor log the FINISH cycle
  endtask

  task automatic wait_rises(input int n);
    int i = 0;
    while (sck_rises < n && i < 1000) begin
      cycle(1);
      i++;
    end
    if (sck_rises < n) check("sck_rise_timeout", 64'(sck_rises), 64'(n));
  endtask

  // -------------------------------------------------------------- stimulus --
  initial begin
    int   fv_base, fe_base, falls_base;
    bit   seen;
    frame_t fa, fb, fc, fd, fe;

    fa = '{f: 16'h1234, c: 16'hABCD, l: 16'h0001, r: 16'hFFFF};
    fb = '{f: 16'h0102, c: 16'h0304, l: 16'h0506, r: 16'h0708};
    fc = '{f: 16'h0A0B, c: 16'h0C0D, l: 16'h0E0F, r: 16'h1011};
    fd = '{f: 16'h4444, c: 16'h3333, l: 16'h2222, r: 16'h1111};
    fe = '{f: 16'h5A5A, c: 16'hC3C3, l: 16'h0F0F, r: 16'h8001};

    rst = 1'b1; enable = 1'b1; data_ready = 1'b0;
    cycle(3);
    check("rst_ss",   64'(spi.ss),   64'd1);
    check("rst_sclk", 64'(spi.sclk), 64'd0);
    check("rst_mosi", 64'(spi.mosi), 64'd0);
    check("rst_busy", 64'(busy),     64'd0);
    check("rst_strobes", 64'({frame_valid, frame_err}), 64'd0);
    check("rst_words", {F, C, L, R}, 64'd0);
    rst = 1'b0;
    cycle(4);

    // Frame A: full-length frame, timing and data.
    launch(fa, 1'b1);
    wait_fv();
    check("A_ss_low_cycles", 64'(ss_low_cnt), 64'(SETUP_CYC + 128 * CLK_DIV + 7 * GAP_CYC + HOLD_CYC));
    check("A_sck_rises",     64'(sck_rises),  64'd64);
    check("A_first_rise",    64'(first_rise), 64'(SETUP_CYC + CLK_DIV));
    // Between bytes SCK stays low for the gap plus the next byte's low phase.
    check("A_byte_gaps",     64'(long_lows),  64'd7);
    check("A_odd_low_runs",  64'(odd_lows),   64'd0);
    check("A_hold",          64'(hold_run),   64'(HOLD_CYC));
    check("A_fv_count",      64'(fv_count),   64'd1);
    check("A_fe_count",      64'(fe_count),   64'd0);
    check("A_idle_ss_busy",  64'({spi.ss, busy}), 64'b10);
    data_ready = 1'b0;
    cycle(6);

    // Abort after byte 3.
    fv_base = fv_count;
    launch(fd, 1'b0);
    wait_rises(32);
    cycle(2);
    data_ready = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      cycle(1);
      if (frame_err) seen = 1'b1;
    end
    check("abort_err_in_4", 64'(seen), 64'd1);
    check("abort_ss_sclk_busy", 64'({spi.ss, spi.sclk, busy}), 64'b100);
    cycle(1);
    check("abort_err_one_cycle", 64'(frame_err), 64'd0);
    check("abort_words_kept", {F, C, L, R}, {fa.f, fa.c, fa.l, fa.r});
    check("abort_no_fv", 64'(fv_count), 64'(fv_base));
    check("abort_fe_count", 64'(fe_count), 64'd1);
    cycle(4);

    // enable low: rise is dropped, and not remembered once enable returns.
    falls_base = ss_falls;
    enable = 1'b0;
    cycle(2);
    data_ready = 1'b1;
    cycle(20);
    check("dis_no_frame", 64'(ss_falls), 64'(falls_base));
    check("dis_ss_busy", 64'({spi.ss, busy}), 64'b10);
    enable = 1'b1;
    cycle(20);
    check("en_no_latched_rise", 64'(ss_falls), 64'(falls_base));
    data_ready = 1'b0;
    cycle(4);

    // Frame B with a sub-cycle glitch on data_ready mid-frame.
    fv_base = fv_count;
    fe_base = fe_count;
    launch(fb, 1'b1);
    wait_rises(10);
    data_ready = 1'b0;
    #2;
    data_ready = 1'b1;
    wait_fv();
    check("B_one_fv", 64'(fv_count), 64'(fv_base + 1));
    check("B_no_err", 64'(fe_count), 64'(fe_base));
    data_ready = 1'b0;
    cycle(3);

    // Frame C back to back; words must hold until FINISH.
    launch(fc, 1'b1);
    wait_rises(5);
    check("C_words_hold", {F, C, L, R}, {fb.f, fb.c, fb.l, fb.r});
    wait_fv();
    check("C_one_fv", 64'(fv_count), 64'(fv_base + 2));
    data_ready = 1'b0;
    cycle(4);

    // Reset mid-byte.
    launch(fd, 1'b0);
    wait_rises(20);
    cycle(1);
    rst = 1'b1;
    data_ready = 1'b0;
    #1;
    check("mid_rst_ss_sclk_busy", 64'({spi.ss, spi.sclk, busy}), 64'b100);
    check("mid_rst_words", {F, C, L, R}, 64'd0);
    check("mid_rst_fv", 64'(frame_valid), 64'd0);
    cycle(3);
    rst = 1'b0;
    cycle(4);

    // Clean frame after reset.
    fe_base = fe_count;
    launch(fe, 1'b1);
    wait_fv();
    check("E_no_err", 64'(fe_count), 64'(fe_base));
    data_ready = 1'b0;
    cycle(4);

    check("sb_drained", 64'(exp_q.size()), 64'd0);
    check("never_both_strobes", 64'(both_high), 64'd0);
    check("mosi_always_0", 64'(mosi_bad), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
